// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin arbiter in front of the 4:1 mux.
// Optional tenure limit is enabled with the ARB_BURST_LIMIT_EN macro in mux_rr_arbiter.
package mux_arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE,
    OWN
  } arb_state_t;

  // Callers guarantee a one-hot or zero vector; zero maps to index 0.
  function automatic logic [1:0] onehot2idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    if (oh[3])      idx = 2'd3;
    else if (oh[2]) idx = 2'd2;
    else if (oh[1]) idx = 2'd1;
    return idx;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Request/grant/select bundle between the requesters, the arbiter and the mux.
// The master modport is the requester side; the slave modport is the arbiter.
interface mux_arb_if;
  import mux_arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic [SEL_W-1:0] sel;
  logic             valid;

  modport master (
    output req,
    input  grant,
    input  sel,
    input  valid
  );

  modport slave (
    input  req,
    output grant,
    output sel,
    output valid
  );

endinterface

// File: rtl/mux_rr_arbiter_pick.sv
// Combinational rotating priority picker: first set request after last_ptr, modulo 4.
// mask_owner removes the current owner so a forced rotation can only land on someone else.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       last_ptr,
  input  logic             mask_owner,
  output logic             any,
  output logic [1:0]       idx,
  output logic [N_REQ-1:0] onehot
);

  logic [N_REQ-1:0] eff_req;
  logic [1:0]       cand;
  logic             found;

  // The owner is scanned last, so it only wins again when nobody else is asking.
  always_comb begin
    eff_req = req;
    if (mask_owner) eff_req[last_ptr] = 1'b0;
    onehot = '0;
    found  = 1'b0;
    cand   = 2'd0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = last_ptr + 2'(k);
      if (!found && eff_req[cand]) begin
        onehot[cand] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  assign any = found;
  assign idx = onehot2idx(onehot);

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the 4:1 mux select; registers a one-hot grant.
// Define ARB_BURST_LIMIT_EN to cap each tenure at MAX_BURST cycles when others wait.
module mux_rr_arbiter
  import mux_arb_pkg::*;
`ifdef ARB_BURST_LIMIT_EN
#(
  parameter int MAX_BURST = 8
)
`endif
(
  input  logic      clk,
  input  logic      rst_n,
  mux_arb_if.slave  bus
);

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [1:0]       last_ptr_q, last_ptr_d;
  logic             valid_q, valid_d;

  logic             pick_any;
  logic [1:0]       pick_idx;
  logic [N_REQ-1:0] pick_onehot;
  logic             mask_owner;

`ifdef ARB_BURST_LIMIT_EN
  logic [7:0] burst_cnt_q, burst_cnt_d;
  logic       burst_hit;

  assign burst_hit  = (burst_cnt_q == 8'(MAX_BURST - 1));
  assign mask_owner = (state_q == OWN) && burst_hit;
`else
  assign mask_owner = 1'b0;
`endif

  rr_pick u_pick (
    .req        (bus.req),
    .last_ptr   (last_ptr_q),
    .mask_owner (mask_owner),
    .any        (pick_any),
    .idx        (pick_idx),
    .onehot     (pick_onehot)
  );

  // In OWN, last_ptr always names the owner, so it doubles as the owner index.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    sel_d      = sel_q;
    last_ptr_d = last_ptr_q;
    valid_d    = valid_q;
`ifdef ARB_BURST_LIMIT_EN
    burst_cnt_d = burst_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d    = OWN;
          grant_d    = pick_onehot;
          sel_d      = pick_idx;
          last_ptr_d = pick_idx;
          valid_d    = 1'b1;
`ifdef ARB_BURST_LIMIT_EN
          burst_cnt_d = 8'd0;
`endif
        end
      end
      OWN: begin
        if (!bus.req[last_ptr_q]) begin
          if (pick_any) begin
            grant_d    = pick_onehot;
            sel_d      = pick_idx;
            last_ptr_d = pick_idx;
`ifdef ARB_BURST_LIMIT_EN
            burst_cnt_d = 8'd0;
`endif
          end else begin
            state_d = IDLE;
            grant_d = '0;
            valid_d = 1'b0;
          end
        end
`ifdef ARB_BURST_LIMIT_EN
        else if (burst_hit) begin
          burst_cnt_d = 8'd0;
          if (pick_any) begin
            grant_d    = pick_onehot;
            sel_d      = pick_idx;
            last_ptr_d = pick_idx;
          end
        end else begin
          burst_cnt_d = burst_cnt_q + 8'd1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // last_ptr resets to 3 so requester 0 is first in line after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      sel_q      <= '0;
      last_ptr_q <= 2'd3;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      sel_q      <= sel_d;
      last_ptr_q <= last_ptr_d;
      valid_q    <= valid_d;
    end
  end

`ifdef ARB_BURST_LIMIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) burst_cnt_q <= 8'd0;
    else        burst_cnt_q <= burst_cnt_d;
  end
`endif

  assign bus.grant = grant_q;
  assign bus.sel   = sel_q;
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed vector table, corner sequences, random vs model.
// Also exercises the tenure limit when built with ARB_BURST_LIMIT_EN.
module tb_mux_rr_arbiter;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mux_arb_if bus ();

  mux_rr_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef ARB_BURST_LIMIT_EN
  localparam int MAX_BURST = 8;
`endif

  typedef struct {
    logic [3:0] req;
    logic [3:0] exp_grant;
    logic [1:0] exp_sel;
    logic       exp_valid;
  } vec_t;

  vec_t vecs[12];

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model: owner index (-1 when idle), rotation pointer, held select, tenure length.
  int m_owner;
  int m_last;
  int m_sel;
  int m_cnt;

  task automatic modelReset();
    m_owner = -1;
    m_last  = 3;
    m_sel   = 0;
    m_cnt   = 0;
  endtask

  function automatic int scanFrom(input logic [3:0] r, input int from, input int exclude);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (from + k) % 4;
      if (r[i] && i != exclude) return i;
    end
    return -1;
  endfunction

  task automatic grantTo(input int i);
    m_owner = i;
    m_last  = i;
    m_sel   = i;
    m_cnt   = 0;
  endtask

  task automatic modelStep(input logic [3:0] r);
    int i;
    if (m_owner < 0) begin
      i = scanFrom(r, m_last, -1);
      if (i >= 0) grantTo(i);
    end else if (!r[m_owner]) begin
      i = scanFrom(r, m_owner, -1);
      if (i >= 0) grantTo(i);
      else m_owner = -1;
    end else begin
`ifdef ARB_BURST_LIMIT_EN
      if (m_cnt == MAX_BURST - 1) begin
        i = scanFrom(r, m_owner, m_owner);
        if (i >= 0) grantTo(i);
        else m_cnt = 0;
      end else begin
        m_cnt = m_cnt + 1;
      end
`endif
    end
  endtask

  function automatic logic [3:0] modelGrant();
    return (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
  endfunction

  // Drive req between edges, let one rising edge sample it, then sample outputs 1 time unit later.
  task automatic applyStimulus(input logic [3:0] r);
    bus.req = r;
    @(posedge clk);
    modelStep(r);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] eg,
                             input logic [1:0] es, input logic ev);
    n_compared++;
    if (bus.grant !== eg || bus.sel !== es || bus.valid !== ev) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got grant=%b sel=%b valid=%b, expected grant=%b sel=%b valid=%b",
               name, bus.grant, bus.sel, bus.valid, eg, es, ev);
    end
  endtask

  task automatic checkModel(input string name);
    checkOutput(name, modelGrant(), 2'(m_sel), (m_owner >= 0));
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", 4'b0000, 2'b00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{4'b1111, 4'b0001, 2'b00, 1'b1};
    vecs[1]  = '{4'b1111, 4'b0001, 2'b00, 1'b1};
    vecs[2]  = '{4'b1111, 4'b0001, 2'b00, 1'b1};
    vecs[3]  = '{4'b1110, 4'b0010, 2'b01, 1'b1};
    vecs[4]  = '{4'b1110, 4'b0010, 2'b01, 1'b1};
    vecs[5]  = '{4'b1100, 4'b0100, 2'b10, 1'b1};
    vecs[6]  = '{4'b1000, 4'b1000, 2'b11, 1'b1};
    vecs[7]  = '{4'b0000, 4'b0000, 2'b11, 1'b0};
    vecs[8]  = '{4'b0100, 4'b0100, 2'b10, 1'b1};
    vecs[9]  = '{4'b1000, 4'b1000, 2'b11, 1'b1};
    vecs[10] = '{4'b0001, 4'b0001, 2'b00, 1'b1};
    vecs[11] = '{4'b0000, 4'b0000, 2'b00, 1'b0};

    rst_n   = 1'b1;
    bus.req = 4'b1111;
    #1;
    doReset();

    for (int v = 0; v < 12; v++) begin
      applyStimulus(vecs[v].req);
      checkOutput($sformatf("vec%0d", v), vecs[v].exp_grant, vecs[v].exp_sel, vecs[v].exp_valid);
    end

    // A request pulse entirely between two edges must never be granted.
    #2 bus.req = 4'b0100;
    #2 bus.req = 4'b0000;
    applyStimulus(4'b0000);
    checkOutput("glitch_ignored", 4'b0000, 2'b00, 1'b0);

    // Asynchronous reset in the middle of a tenure.
    applyStimulus(4'b1000);
    checkOutput("pre_async_reset", 4'b1000, 2'b11, 1'b1);
    #2 rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("async_reset_drop", 4'b0000, 2'b00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'b0010);
    checkOutput("post_reset_req1", 4'b0010, 2'b01, 1'b1);

`ifdef ARB_BURST_LIMIT_EN
    bus.req = 4'b0000;
    doReset();
    for (int c = 0; c < 3 * MAX_BURST; c++) begin
      applyStimulus(4'b0011);
      if (((c / MAX_BURST) % 2) == 0)
        checkOutput($sformatf("burst_c%0d", c), 4'b0001, 2'b00, 1'b1);
      else
        checkOutput($sformatf("burst_c%0d", c), 4'b0010, 2'b01, 1'b1);
    end
    for (int c = 0; c < 3 * MAX_BURST; c++) begin
      applyStimulus(4'b0001);
      checkOutput($sformatf("burst_alone_c%0d", c), 4'b0001, 2'b00, 1'b1);
    end
`endif

    // Random requests, mostly held for several cycles so tenures and rotations both occur.
    bus.req = 4'b0000;
    doReset();
    begin
      logic [3:0] r;
      r = 4'b0000;
      for (int c = 0; c < 600; c++) begin
        if ($urandom_range(3) == 0) r = 4'($urandom_range(15));
        applyStimulus(r);
        checkModel($sformatf("rand_c%0d", c));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
